fht_input_loader: RTL and testbench

- Upstream stage of fht_control.
- Accepts a serial stream of time-domain samples over a valid/ready handshake and writes them into the four FHT RAM banks in bit-reversed order.
- Once the full frame is stored, it issues a one-cycle start pulse to fht_control and holds off new input until fht_control reports completion via its ready flag.

---
 rtl/fht_input_loader_if.sv | 29 ++
 rtl/fht_input_loader.sv | 122 ++++++++++++
 tb/tb_fht_input_loader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fht_input_loader_if.sv
// Sample-stream and FHT bank-write bundle between the loader, its sample
// source and the fht_control RAM banks / handshake.
interface fht_input_loader_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
);
  logic             iVALID;
  logic [D_BIT-1:0] iDATA;
  logic             oREADY;
  logic [A_BIT-1:0] oADDR;
  logic [D_BIT-1:0] oDATA;
  logic [3:0]       oWE;
  logic             oSTART;
  logic             iFHT_RDY;
  logic             oBUSY;
  logic [A_BIT+1:0] oCNT;

  // loader side
  modport slave (
    input  iVALID, iDATA, iFHT_RDY,
    output oREADY, oADDR, oDATA, oWE, oSTART, oBUSY, oCNT
  );

  // source / environment side
  modport master (
    output iVALID, iDATA, iFHT_RDY,
    input  oREADY, oADDR, oDATA, oWE, oSTART, oBUSY, oCNT
  );
endinterface

// File: rtl/fht_input_loader.sv
// FHT input loader: takes N = 4*2^A_BIT serial samples, scatters them into
// the four FHT banks at bit-reversed positions, pulses start to fht_control
// and then blocks input until fht_control goes busy and back to idle.
module fht_input_loader #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic                iCLK,
  input  logic                iRESET,
  fht_input_loader_if.slave   bus
);

  localparam int CW = A_BIT + 2;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    START   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  // one registered bank write
  typedef struct packed {
    logic [3:0]       we;
    logic [A_BIT-1:0] addr;
    logic [D_BIT-1:0] data;
  } wr_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  wr_t             wr_q, wr_d;

  logic            accept;
  logic [CW-1:0]   rev;
  logic [1:0]      bank;

  // ready is a flop so it stays low through reset and rises one edge later
  assign accept = bus.iVALID & rdy_q & (state_q == LOAD);

  // bit-reverse the current index; top two bits pick the bank
  always_comb begin
    rev = '0;
    for (int k = 0; k < CW; k++) rev[k] = cnt_q[CW-1-k];
  end

  assign bank = rev[CW-1 -: 2];

  // next state and sample counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + CW'(1);   // last sample wraps to 0 naturally
          if (cnt_q == {CW{1'b1}}) state_d = START;
        end
      end
      START:   state_d = WAIT_LO;
      WAIT_LO: if (!bus.iFHT_RDY) state_d = WAIT_HI;
      WAIT_HI: begin
        if (bus.iFHT_RDY) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // status flags registered from the next state so they line up with it
  always_comb begin
    rdy_d   = (state_d == LOAD);
    start_d = (state_d == START);
    busy_d  = (state_d == WAIT_LO) || (state_d == WAIT_HI);
  end

  // write port: one-cycle enable per accepted sample, address/data hold
  always_comb begin
    wr_d    = wr_q;
    wr_d.we = '0;
    if (accept) begin
      wr_d.we   = 4'b0001 << bank;
      wr_d.addr = rev[A_BIT-1:0];
      wr_d.data = bus.iDATA;
    end
  end

  // state register
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.oREADY = rdy_q;
  assign bus.oSTART = start_q;
  assign bus.oBUSY  = busy_q;
  assign bus.oWE    = wr_q.we;
  assign bus.oADDR  = wr_q.addr;
  assign bus.oDATA  = wr_q.data;
  assign bus.oCNT   = cnt_q;

endmodule

// File: tb/tb_fht_input_loader.sv
// Randomized self-checking bench for fht_input_loader at A_BIT=2 (N=16).
module tb_fht_input_loader;
  localparam int A_BIT = 2;
  localparam int D_BIT = 16;
  localparam int N     = 4 << A_BIT;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fht_input_loader_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

  fht_input_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // index -> bit-reversed position over log2(N) bits, by plain arithmetic
  function automatic int bitrev(input int i);
    int r = 0;
    int x = i;
    for (int b = 0; b < A_BIT + 2; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic check_cleared(input string tag);
    chk({tag, "_ready"}, bus.oREADY, 0);
    chk({tag, "_we"},    bus.oWE,    0);
    chk({tag, "_addr"},  bus.oADDR,  0);
    chk({tag, "_data"},  bus.oDATA,  0);
    chk({tag, "_start"}, bus.oSTART, 0);
    chk({tag, "_busy"},  bus.oBUSY,  0);
    chk({tag, "_cnt"},   bus.oCNT,   0);
  endtask

  // asynchronous reset for a few cycles, then release
  task automatic do_reset(input int cycles);
    #2 rst = 1'b1;
    bus.iVALID = 1'b0;
    #1 check_cleared("rst");
    repeat (cycles) step;
    check_cleared("rst_hold");
    rst = 1'b0;
    #1 chk("rel_ready_pre", bus.oREADY, 0);
    step;
    chk("rel_ready", bus.oREADY, 1);
    chk("rel_we",    bus.oWE,    0);
    chk("rel_cnt",   bus.oCNT,   0);
  endtask

  // offer samples until n_acc have been accepted; each must land at its
  // bit-reversed bank/address the cycle after acceptance
  task automatic run_frame(input int n_acc, input bit gaps, input bit seq_data);
    int  i = 0;
    int  guard = 0;
    int  hits = 0;
    bit  mark [N];
    bit  v;
    logic [D_BIT-1:0] d;
    int  r;
    for (int k = 0; k < N; k++) mark[k] = 1'b0;
    while (i < n_acc && guard < 400) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = seq_data ? D_BIT'(100 + i) : D_BIT'($urandom);
      chk("ld_ready", bus.oREADY, 1);
      bus.iVALID = v;
      bus.iDATA  = d;
      step;
      guard++;
      if (v) begin
        r = bitrev(i);
        chk("wr_we",   bus.oWE,   32'(4'b0001 << (r / (N / 4))));
        chk("wr_addr", bus.oADDR, r % (N / 4));
        chk("wr_data", bus.oDATA, d);
        chk("wr_dup",  mark[r],   0);
        mark[r] = 1'b1;
        i++;
      end else begin
        chk("gap_we", bus.oWE, 0);
      end
      chk("ld_cnt",   bus.oCNT,   i % N);
      chk("ld_start", bus.oSTART, (v && i == N) ? 1 : 0);
    end
    if (guard >= 400) chk("ld_timeout", 0, 1);
    if (n_acc == N) begin
      for (int k = 0; k < N; k++) hits += mark[k];
      chk("frame_cover", hits, N);
      chk("st_ready", bus.oREADY, 0);
      chk("st_busy",  bus.oBUSY,  0);
    end
    bus.iVALID = 1'b0;
  endtask

  // fht_control handshake: completion is the first rising level after the
  // first low seen once the start cycle is over
  task automatic run_busy(input bit fixed);
    logic r [64];
    int   len;
    int   h, z, e1, e2;
    if (fixed) begin
      h = 5; z = 20;
      for (int j = 0; j < h; j++) r[j] = 1'b1;
      for (int j = h; j < h + z; j++) r[j] = 1'b0;
      r[h + z] = 1'b1;
      len = h + z + 1;
    end else begin
      h = $urandom_range(0, 5);
      z = $urandom_range(1, 20);
      r[0] = 1'($urandom_range(0, 1));
      for (int j = 1; j <= h; j++) r[j] = 1'b1;
      for (int j = h + 1; j <= h + z; j++) r[j] = 1'b0;
      r[h + z + 1] = 1'b1;
      len = h + z + 2;
    end
    e1 = -1; e2 = -1;
    for (int j = 1; j < len; j++) if (e1 < 0 && r[j] == 1'b0) e1 = j;
    for (int j = e1 + 1; j < len; j++) if (e2 < 0 && r[j] == 1'b1) e2 = j;
    for (int j = 0; j <= e2; j++) begin
      bus.iFHT_RDY = r[j];
      bus.iVALID   = 1'($urandom_range(0, 1));
      bus.iDATA    = D_BIT'($urandom);
      step;
      chk("bz_we",    bus.oWE,    0);
      chk("bz_start", bus.oSTART, 0);
      if (j < e2) begin
        chk("bz_busy",  bus.oBUSY,  1);
        chk("bz_ready", bus.oREADY, 0);
      end else begin
        chk("done_busy",  bus.oBUSY,  0);
        chk("done_ready", bus.oREADY, 1);
        chk("done_cnt",   bus.oCNT,   0);
      end
    end
    bus.iFHT_RDY = 1'b1;
    bus.iVALID   = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.iVALID   = 1'b0;
    bus.iDATA    = '0;
    bus.iFHT_RDY = 1'b1;
    repeat (3) step;
    do_reset(1);
    run_frame(N, 1'b0, 1'b1);
    run_busy(1'b1);
    run_frame(N, 1'b1, 1'b1);
    run_busy(1'b0);
    run_frame(7, 1'b1, 1'b0);
    do_reset(2);
    run_frame(N, 1'b0, 1'b0);
    run_busy(1'b0);
    for (int f = 0; f < 4; f++) begin
      run_frame(N, 1'($urandom_range(0, 1)), 1'b0);
      run_busy(1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
